// File: rtl/mem_ctrl.sv
// Single-port controller that serialises IF fetches and MEM loads/stores onto a byte-wide sync RAM.
// Reads assemble little-endian words; every transaction ends with a one-cycle completion pulse.
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              IF_req_in,
  input  logic [ADDR_W-1:0] IF_addr_in,
  input  logic              IF_flush_in,
  output logic              IF_dataE_out,
  output logic [31:0]       IF_data_out,
  input  logic              MEM_req_in,
  input  logic              MEM_rw_in,
  input  logic [ADDR_W-1:0] MEM_addr_in,
  input  logic [31:0]       MEM_data_in,
  input  logic [2:0]        MEM_len_in,
  output logic              MEM_dataE_out,
  output logic [31:0]       MEM_data_out,
  output logic              busy_out,
  output logic [ADDR_W-1:0] ram_addr_out,
  output logic              ram_wr_out,
  output logic [7:0]        ram_dout_out,
  input  logic [7:0]        ram_din_in
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_own_mem;
  logic [2:0]  r_len;
  logic [2:0]  r_cnt;
  logic [31:0] r_wdata;
  logic [31:0] r_buf;

  logic [2:0]  w_mem_len;
  logic        w_flush;
  logic        w_rd_last;
  logic        w_wr_last;
  logic [31:0] w_buf_next;

  assign w_mem_len = (MEM_len_in > 3'd4) ? 3'd4 : MEM_len_in;
  assign w_flush   = IF_flush_in & ~r_own_mem;
  assign w_rd_last = (r_cnt == r_len);
  assign w_wr_last = ((r_cnt + 3'd1) == r_len);
  assign busy_out  = (r_state != S_IDLE);

  // Byte returned now belongs to the address presented one cycle earlier (lane r_cnt-1)
  always_comb begin
    w_buf_next = r_buf;
    case (r_cnt)
      3'd1:    w_buf_next[7:0]   = ram_din_in;
      3'd2:    w_buf_next[15:8]  = ram_din_in;
      3'd3:    w_buf_next[23:16] = ram_din_in;
      3'd4:    w_buf_next[31:24] = ram_din_in;
      default: w_buf_next = r_buf;
    endcase
  end

  // Transaction sequencer: arbitration, byte stepping and completion pulses
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state       <= S_IDLE;
      r_own_mem     <= 1'b0;
      r_len         <= 3'd0;
      r_cnt         <= 3'd0;
      r_wdata       <= 32'd0;
      r_buf         <= 32'd0;
      IF_dataE_out  <= 1'b0;
      IF_data_out   <= 32'd0;
      MEM_dataE_out <= 1'b0;
      MEM_data_out  <= 32'd0;
      ram_addr_out  <= {ADDR_W{1'b0}};
      ram_wr_out    <= 1'b0;
      ram_dout_out  <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          IF_dataE_out  <= 1'b0;
          MEM_dataE_out <= 1'b0;
          r_cnt         <= 3'd0;
          r_buf         <= 32'd0;
          if (MEM_req_in) begin
            // a zero-length MEM request is dropped and still blocks IF this cycle
            if (w_mem_len != 3'd0) begin
              r_own_mem    <= 1'b1;
              r_len        <= w_mem_len;
              ram_addr_out <= MEM_addr_in;
              if (MEM_rw_in) begin
                r_state      <= S_WRITE;
                ram_wr_out   <= 1'b1;
                ram_dout_out <= MEM_data_in[7:0];
                r_wdata      <= {8'd0, MEM_data_in[31:8]};
              end else begin
                r_state <= S_READ;
              end
            end else begin
              r_state <= S_IDLE;
            end
          end else if (IF_req_in) begin
            r_own_mem    <= 1'b0;
            r_len        <= 3'd4;
            ram_addr_out <= IF_addr_in;
            r_state      <= S_READ;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_READ: begin
          if (w_flush) begin
            r_state <= S_IDLE;
            r_buf   <= 32'd0;
            r_cnt   <= 3'd0;
          end else if (w_rd_last) begin
            r_state <= S_DONE;
            if (r_own_mem) begin
              MEM_data_out  <= w_buf_next;
              MEM_dataE_out <= 1'b1;
            end else begin
              IF_data_out  <= w_buf_next;
              IF_dataE_out <= 1'b1;
            end
          end else begin
            r_buf <= w_buf_next;
            r_cnt <= r_cnt + 3'd1;
            if ((r_cnt + 3'd1) < r_len) begin
              ram_addr_out <= ram_addr_out + ADDR_W'(1);
            end else begin
              ram_addr_out <= ram_addr_out;
            end
          end
        end
        S_WRITE: begin
          if (w_wr_last) begin
            r_state       <= S_DONE;
            ram_wr_out    <= 1'b0;
            MEM_dataE_out <= 1'b1;
          end else begin
            r_cnt        <= r_cnt + 3'd1;
            ram_addr_out <= ram_addr_out + ADDR_W'(1);
            ram_dout_out <= r_wdata[7:0];
            r_wdata      <= {8'd0, r_wdata[31:8]};
          end
        end
        S_DONE: begin
          r_state       <= S_IDLE;
          IF_dataE_out  <= 1'b0;
          MEM_dataE_out <= 1'b0;
        end
        default: begin
          r_state    <= S_IDLE;
          ram_wr_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: a byte RAM model, expected reads/writes queued at stimulus time.
module tb_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_de;
  logic [31:0] if_data;
  logic        mem_req;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_len;
  logic        mem_de;
  logic [31:0] mem_rdata;
  logic        busy;
  logic [31:0] ram_addr;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] if_q[$];
  logic [31:0] mem_q[$];
  logic [39:0] wr_q[$];

  logic [7:0] ram_mem [0:1023];
  bit         ram_vld [0:1023];
  logic [7:0] ref_mem [0:1023];
  bit         ref_vld [0:1023];
  logic [31:0] last_mem_rd;

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk_in(clk), .rst_in(rst_n),
    .IF_req_in(if_req), .IF_addr_in(if_addr), .IF_flush_in(if_flush),
    .IF_dataE_out(if_de), .IF_data_out(if_data),
    .MEM_req_in(mem_req), .MEM_rw_in(mem_rw), .MEM_addr_in(mem_addr),
    .MEM_data_in(mem_wdata), .MEM_len_in(mem_len),
    .MEM_dataE_out(mem_de), .MEM_data_out(mem_rdata),
    .busy_out(busy), .ram_addr_out(ram_addr), .ram_wr_out(ram_wr),
    .ram_dout_out(ram_dout), .ram_din_in(ram_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pattern(input logic [9:0] a);
    logic [9:0] t;
    if (a == 10'h100) return 8'h13;
    if (a == 10'h101 || a == 10'h102 || a == 10'h103) return 8'h00;
    if (a == 10'h008) return 8'h80;
    t = a * 10'd7 + 10'd3;
    return t[7:0];
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_vld[a[9:0]] ? ref_mem[a[9:0]] : pattern(a[9:0]);
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Synchronous byte RAM: read data appears the cycle after the address
  always @(posedge clk) begin
    if (ram_wr) begin
      ram_mem[ram_addr[9:0]] <= ram_dout;
      ram_vld[ram_addr[9:0]] <= 1'b1;
    end
    ram_din <= ram_vld[ram_addr[9:0]] ? ram_mem[ram_addr[9:0]] : pattern(ram_addr[9:0]);
  end

  // Scoreboard monitor: completions and RAM writes are matched against queued expectations
  always @(negedge clk) begin
    if (if_de && mem_de) check_eq("both_dataE", 64'd1, 64'd0);
    if (if_de) begin
      if (if_q.size() == 0) check_eq("if_unexpected", 64'd1, 64'd0);
      else check_eq("if_data", {32'd0, if_data}, {32'd0, if_q.pop_front()});
    end
    if (mem_de && !mem_rw) begin
      if (mem_q.size() == 0) check_eq("mem_unexpected", 64'd1, 64'd0);
      else check_eq("mem_data", {32'd0, mem_rdata}, {32'd0, mem_q.pop_front()});
    end
    if (ram_wr) begin
      if (wr_q.size() == 0) check_eq("wr_unexpected", 64'd1, 64'd0);
      else check_eq("wr_addr_byte", {24'd0, ram_addr, ram_dout}, {24'd0, wr_q.pop_front()});
    end
  end

  task automatic run_txn(input bit is_mem, input bit rw, input logic [31:0] addr,
                         input logic [31:0] data, input logic [2:0] len);
    int n;
    int lat;
    int exp_lat;
    logic [31:0] exp;
    logic [31:0] a;
    n = is_mem ? ((len > 3'd4) ? 4 : int'(len)) : 4;
    exp = 32'd0;
    for (int i = 0; i < n; i++) begin
      a = addr + i;
      if (is_mem && rw) begin
        wr_q.push_back({a, data[8*i +: 8]});
        ref_mem[a[9:0]] = data[8*i +: 8];
        ref_vld[a[9:0]] = 1'b1;
      end else begin
        exp[8*i +: 8] = ref_rd(a);
      end
    end
    if (!(is_mem && rw)) begin
      if (is_mem) begin
        mem_q.push_back(exp);
        last_mem_rd = exp;
      end else begin
        if_q.push_back(exp);
      end
    end
    exp_lat = (is_mem && rw) ? n : n + 1;
    if (is_mem) begin
      mem_req = 1'b1; mem_rw = rw; mem_addr = addr; mem_wdata = data; mem_len = len;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      check_eq("busy", {63'd0, busy}, 64'd1);
      if (is_mem && rw) begin
        check_eq("wr_strobe", {63'd0, ram_wr}, {63'd0, k < n});
      end else begin
        check_eq("rd_no_wr", {63'd0, ram_wr}, 64'd0);
        if (k < n) check_eq("rd_addr", {32'd0, ram_addr}, {32'd0, addr + k});
      end
      if ((is_mem && mem_de) || (!is_mem && if_de)) begin
        lat = k;
        mem_req = 1'b0;
        if_req = 1'b0;
        break;
      end
    end
    check_eq("latency", 64'(lat), 64'(exp_lat));
    mem_req = 1'b0;
    if_req = 1'b0;
    @(negedge clk);
    check_eq("idle_after", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int mlat;
    int ilat;
    int k;
    rst_n = 1'b0; if_req = 1'b0; if_addr = 32'd0; if_flush = 1'b0;
    mem_req = 1'b0; mem_rw = 1'b0; mem_addr = 32'd0; mem_wdata = 32'd0; mem_len = 3'd0;
    last_mem_rd = 32'd0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_outs", {if_de, mem_de, ram_wr, if_data, ram_dout}, 64'd0);
    check_eq("rst_data", {mem_rdata, ram_addr}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(1'b0, 1'b0, 32'h100, 32'd0, 3'd4);
    run_txn(1'b1, 1'b1, 32'h200, 32'hAABBCCDD, 3'd2);
    run_txn(1'b1, 1'b0, 32'h200, 32'd0, 3'd2);

    // Simultaneous IF and MEM: MEM first, IF after one idle cycle
    mem_q.push_back({24'd0, ref_rd(32'h8)});
    if_q.push_back({ref_rd(32'h107), ref_rd(32'h106), ref_rd(32'h105), ref_rd(32'h104)});
    mem_req = 1'b1; mem_rw = 1'b0; mem_addr = 32'h8; mem_len = 3'd1;
    if_req = 1'b1; if_addr = 32'h104;
    mlat = -1; ilat = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (mem_de) begin mlat = c; mem_req = 1'b0; end
      if (if_de) begin ilat = c; if_req = 1'b0; break; end
    end
    check_eq("arb_mem_lat", 64'(mlat), 64'd2);
    check_eq("arb_if_lat", 64'(ilat), 64'd9);
    mem_req = 1'b0; if_req = 1'b0;
    @(negedge clk);

    // Flush an IF fetch in cycle 2, then a new fetch is accepted right away
    if_req = 1'b1; if_addr = 32'h120;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("flush_busy", {63'd0, busy}, 64'd1);
    end
    if_flush = 1'b1; if_addr = 32'h140;
    @(negedge clk);
    if_flush = 1'b0;
    check_eq("flush_idle", {63'd0, busy}, 64'd0);
    check_eq("flush_no_de", {63'd0, if_de}, 64'd0);
    if_q.push_back({ref_rd(32'h143), ref_rd(32'h142), ref_rd(32'h141), ref_rd(32'h140)});
    k = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (if_de) begin k = c; if_req = 1'b0; break; end
    end
    check_eq("flush_refetch_lat", 64'(k), 64'd5);
    if_req = 1'b0;
    @(negedge clk);

    run_txn(1'b1, 1'b0, 32'hFFFFFFFE, 32'd0, 3'd4);
    run_txn(1'b1, 1'b0, 32'h40, 32'd0, 3'd3);
    run_txn(1'b1, 1'b0, 32'h50, 32'd0, 3'd6);

    // Zero length MEM request is ignored
    mem_req = 1'b1; mem_rw = 1'b1; mem_addr = 32'h60; mem_len = 3'd0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("len0_idle", {62'd0, busy, ram_wr}, 64'd0);
    end
    mem_req = 1'b0;
    @(negedge clk);

    run_txn(1'b0, 1'b0, 32'h60, 32'd0, 3'd4);
    check_eq("mem_data_hold", {32'd0, mem_rdata}, {32'd0, last_mem_rd});

    // Reset in cycle 1 of a 4-byte write
    for (int i = 0; i < 4; i++) wr_q.push_back({32'h300 + i, 8'h44 - 8'(i * 17)});
    mem_req = 1'b1; mem_rw = 1'b1; mem_addr = 32'h300; mem_wdata = 32'h11223344; mem_len = 3'd4;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_wr", {63'd0, ram_wr}, 64'd0);
    check_eq("arst_outs", {busy, if_de, mem_de, if_data, ram_dout}, 64'd0);
    check_eq("arst_data", {mem_rdata, ram_addr}, 64'd0);
    check_eq("arst_writes_done", 64'(wr_q.size()), 64'd2);
    wr_q.delete();
    mem_req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_eq("arst_hold", {61'd0, busy, mem_de, ram_wr}, 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    run_txn(1'b0, 1'b0, 32'h100, 32'd0, 3'd4);

    check_eq("if_q_empty", 64'(if_q.size()), 64'd0);
    check_eq("mem_q_empty", 64'(mem_q.size()), 64'd0);
    check_eq("wr_q_empty", 64'(wr_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
